// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch <-> instruction-memory bundle.
// master = fetch side, slave = memory side.
//   req_valid/req_pc/req_ready    PC request handshake
//   flush                         redirect, kills in-flight responses
//   resp_valid/resp_ready         response handshake
//   resp_pc/resp_instr/resp_fault response payload
//   ld_we/ld_addr/ld_data         write-only array load port
interface imem_responder_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 12,
  parameter int DEPTH_WORDS = 1024
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic                   req_valid;
  logic [PC_WIDTH-1:0]    req_pc;
  logic                   req_ready;
  logic                   flush;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [PC_WIDTH-1:0]    resp_pc;
  logic [INSTR_WIDTH-1:0] resp_instr;
  logic                   resp_fault;
  logic                   ld_we;
  logic [AW-1:0]          ld_addr;
  logic [INSTR_WIDTH-1:0] ld_data;

  modport master (
    output req_valid, req_pc, flush,
    output resp_ready,
    output ld_we, ld_addr, ld_data,
    input  req_ready,
    input  resp_valid, resp_pc,
    input  resp_instr, resp_fault
  );

  modport slave (
    input  req_valid, req_pc, flush,
    input  resp_ready,
    input  ld_we, ld_addr, ld_data,
    output req_ready,
    output resp_valid, resp_pc,
    output resp_instr, resp_fault
  );
endinterface

// File: rtl/imem_responder.sv
// imem_responder: memory side of fetch; returns the word at each
// requested PC after LATENCY cycles, in order, with flush and backpressure.
// Ports: clk, rst (async active-low), bus (imem_responder_if.slave).
module imem_responder #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 12,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
  input logic              clk,
  input logic              rst,
  imem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int XW = PC_WIDTH - 2;

  logic [INSTR_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [LATENCY-1:0]     sv;
  logic [LATENCY-1:0]     sf;
  logic [PC_WIDTH-1:0]    spc [LATENCY];
  logic [INSTR_WIDTH-1:0] sins [LATENCY];

  logic                   advance;
  logic                   accept;
  logic [XW-1:0]          idx;
  logic                   in_range;
  logic                   fault;
  logic [INSTR_WIDTH-1:0] rd_word;

  assign advance = !sv[LATENCY-1] || bus.resp_ready;

  // A redirect must never be blocked by a stalled consumer.
  assign bus.req_ready = advance || bus.flush;
  assign accept = bus.req_valid && bus.req_ready;

  assign idx      = bus.req_pc[PC_WIDTH-1:2];
  assign in_range = 32'(idx) < 32'(DEPTH_WORDS);
  assign fault    = (bus.req_pc[1:0] != 2'b00) || !in_range;
  assign rd_word  = mem[idx[AW-1:0]];

  // Non-blocking write: a same-cycle read still sees the old word.
  always_ff @(posedge clk) begin
    if (bus.ld_we) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sv <= '0;
      sf <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        spc[i]  <= '0;
        sins[i] <= NOP_INSTR;
      end
    end else if (advance || bus.flush) begin
      sv[0] <= accept;
      if (accept) begin
        spc[0]  <= bus.req_pc;
        sf[0]   <= fault;
        sins[0] <= fault ? NOP_INSTR : rd_word;
      end
      for (int i = 1; i < LATENCY; i++) begin
        sv[i]   <= bus.flush ? 1'b0 : sv[i-1];
        sf[i]   <= sf[i-1];
        spc[i]  <= spc[i-1];
        sins[i] <= sins[i-1];
      end
    end
  end

  assign bus.resp_valid = sv[LATENCY-1];
  assign bus.resp_pc    = spc[LATENCY-1];
  assign bus.resp_instr = sins[LATENCY-1];
  assign bus.resp_fault = sf[LATENCY-1];
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: scoreboard bench for imem_responder.
// Depth is reduced so out-of-range PCs fit in the 12-bit request PC.
module tb_imem_responder;
  localparam int IW  = 32;
  localparam int PW  = 12;
  localparam int DW  = 512;
  localparam int LAT = 2;
  localparam int AW  = $clog2(DW);
  localparam logic [IW-1:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] instr;
    logic          fault;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_responder_if #(
    .INSTR_WIDTH(IW), .PC_WIDTH(PW), .DEPTH_WORDS(DW)
  ) bus ();

  imem_responder #(
    .INSTR_WIDTH(IW), .PC_WIDTH(PW), .DEPTH_WORDS(DW),
    .LATENCY(LAT), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  rsp_t        q[$];
  logic [IW-1:0] mm [DW];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  function automatic rsp_t model(input logic [PW-1:0] pc);
    rsp_t r;
    int   w;
    w = int'(pc[PW-1:2]);
    r.pc = pc;
    if (pc[1:0] != 2'b00 || w >= DW) begin
      r.instr = NOP;
      r.fault = 1'b1;
    end else begin
      r.instr = mm[w];
      r.fault = 1'b0;
    end
    return r;
  endfunction

  task automatic idle();
    bus.req_valid  = 1'b0;
    bus.req_pc     = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b1;
    bus.ld_we      = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
  endtask

  // One clock: sample handshakes, update scoreboard and model memory.
  task automatic clk_step(output bit acc, output bit fired,
                          output bit unexp, output rsp_t exp,
                          output rsp_t got);
    bit            w;
    logic [AW-1:0] wa;
    logic [IW-1:0] wd;
    #1;
    acc   = bus.req_valid && bus.req_ready;
    fired = bus.resp_valid && bus.resp_ready;
    unexp = 1'b0;
    exp   = '0;
    got   = '0;
    if (fired) begin
      got = {bus.resp_pc, bus.resp_instr, bus.resp_fault};
      if (q.size() == 0) unexp = 1'b1;
      else exp = q.pop_front();
    end
    if (bus.flush) q.delete();
    if (acc) q.push_back(model(bus.req_pc));
    w  = bus.ld_we;
    wa = bus.ld_addr;
    wd = bus.ld_data;
    @(posedge clk);
    if (w) mm[int'(wa)] = wd;
    cyc++;
    #1;
  endtask

  task automatic preload();
    bit a, f, u;
    rsp_t e, g;
    for (int i = 0; i < 8; i++) begin
      bus.ld_we   = 1'b1;
      bus.ld_addr = AW'(i);
      bus.ld_data = 32'hA0 + IW'(i);
      clk_step(a, f, u, e, g);
    end
    bus.ld_addr = AW'(DW - 1);
    bus.ld_data = 32'hBB;
    clk_step(a, f, u, e, g);
    bus.ld_we = 1'b0;
  endtask

  task automatic test_reset();
    bit a, f, u;
    rsp_t e, g;
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.resp_instr !== NOP ||
        bus.resp_pc !== '0 || bus.resp_fault !== 1'b0 ||
        bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b pc=%h i=%h f=%b rr=%b, want 0 000 %h 0 1",
               bus.resp_valid, bus.resp_pc, bus.resp_instr,
               bus.resp_fault, bus.req_ready, NOP);
    end
    rst = 1'b1;
    clk_step(a, f, u, e, g);
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.resp_instr !== NOP) begin
      n_bad++;
      $display("FAIL reset_release: got v=%b i=%h, want 0 %h",
               bus.resp_valid, bus.resp_instr, NOP);
    end
    preload();
  endtask

  task automatic test_stream();
    logic [PW-1:0] pcs [4] = '{12'h000, 12'h004, 12'h008, 12'h00C};
    int   i = 0, nf = 0, fa = -1, f0 = -1, fl = -1, t;
    bit   a, f, u;
    rsp_t e, g;
    idle();
    for (int c = 0; c < 20 && nf < 4; c++) begin
      bus.req_valid = (i < 4);
      if (i < 4) bus.req_pc = pcs[i];
      t = cyc;
      clk_step(a, f, u, e, g);
      if (a) begin
        if (fa < 0) fa = t;
        i++;
      end
      if (f) begin
        n_cmp++;
        if (u || g !== e) begin
          n_bad++;
          $display("FAIL stream_resp: got %h/%h/%b, want %h/%h/%b extra=%b",
                   g.pc, g.instr, g.fault, e.pc, e.instr, e.fault, u);
        end
        if (f0 < 0) f0 = t;
        fl = t;
        nf++;
      end
    end
    bus.req_valid = 1'b0;
    n_cmp++;
    if (nf != 4) begin
      n_bad++;
      $display("FAIL stream_count: got %0d, want 4", nf);
    end
    n_cmp++;
    if (f0 - fa != LAT) begin
      n_bad++;
      $display("FAIL first_latency: got %0d, want %0d", f0 - fa, LAT);
    end
    n_cmp++;
    if (fl - f0 != 3) begin
      n_bad++;
      $display("FAIL back_to_back: got span %0d, want 3", fl - f0);
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] pcs [4] = '{12'h000, 12'h004, 12'h008, 12'h00C};
    int   i = 0, nf = 0, held = 0;
    bit   a, f, u;
    rsp_t e, g, hv, cur;
    rsp_t want_h;
    want_h = {12'h004, 32'hA1, 1'b0};
    idle();
    for (int c = 0; c < 30 && nf < 4; c++) begin
      bus.req_valid = (i < 4);
      if (i < 4) bus.req_pc = pcs[i];
      if (bus.resp_valid && bus.resp_pc == 12'h004 && held < 3) begin
        bus.resp_ready = 1'b0;
        #1;
        cur = {bus.resp_pc, bus.resp_instr, bus.resp_fault};
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL hold_req_ready: got %b, want 0", bus.req_ready);
        end
        if (held == 0) begin
          hv = cur;
          n_cmp++;
          if (hv !== want_h) begin
            n_bad++;
            $display("FAIL hold_value: got %h/%h, want 004/000000a1",
                     hv.pc, hv.instr);
          end
        end else begin
          n_cmp++;
          if (cur !== hv) begin
            n_bad++;
            $display("FAIL hold_stable: got %h/%h, want %h/%h",
                     cur.pc, cur.instr, hv.pc, hv.instr);
          end
        end
        held++;
      end else begin
        bus.resp_ready = 1'b1;
      end
      clk_step(a, f, u, e, g);
      if (a) i++;
      if (f) begin
        n_cmp++;
        if (u || g !== e) begin
          n_bad++;
          $display("FAIL bp_resp: got %h/%h/%b, want %h/%h/%b extra=%b",
                   g.pc, g.instr, g.fault, e.pc, e.instr, e.fault, u);
        end
        nf++;
      end
    end
    idle();
    n_cmp++;
    if (nf != 4 || held != 3 || q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_count: got nf=%0d held=%0d left=%0d, want 4 3 0",
               nf, held, q.size());
    end
  endtask

  task automatic test_flush();
    logic [PW-1:0] pcs [3] = '{12'h000, 12'h004, 12'h008};
    int   nf = 0;
    bit   a, f, u;
    rsp_t e, g;
    idle();
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.req_valid = 1'b1;
      bus.req_pc    = pcs[k];
      clk_step(a, f, u, e, g);
    end
    bus.flush  = 1'b1;
    bus.req_pc = 12'h040;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_req_ready: got %b, want 1", bus.req_ready);
    end
    clk_step(a, f, u, e, g);
    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      clk_step(a, f, u, e, g);
      if (f) begin
        n_cmp++;
        if (u || g !== e || g.pc !== 12'h040) begin
          n_bad++;
          $display("FAIL flush_resp: got %h/%h, want 040/%h extra=%b",
                   g.pc, g.instr, e.instr, u);
        end
        nf++;
      end
    end
    n_cmp++;
    if (nf != 1) begin
      n_bad++;
      $display("FAIL flush_count: got %0d, want 1", nf);
    end
  endtask

  task automatic test_fault();
    logic [PW-1:0] pcs [5] = '{12'h006, 12'h800, 12'h7FC, 12'hFFC, 12'h000};
    int   i = 0, nf = 0;
    bit   a, f, u;
    rsp_t e, g;
    idle();
    for (int c = 0; c < 20 && nf < 5; c++) begin
      bus.req_valid = (i < 5);
      if (i < 5) bus.req_pc = pcs[i];
      clk_step(a, f, u, e, g);
      if (a) i++;
      if (f) begin
        n_cmp++;
        if (u || g !== e) begin
          n_bad++;
          $display("FAIL fault_resp: got %h/%h/%b, want %h/%h/%b extra=%b",
                   g.pc, g.instr, g.fault, e.pc, e.instr, e.fault, u);
        end
        if (nf < 2) begin
          n_cmp++;
          if (g.fault !== 1'b1 || g.instr !== NOP) begin
            n_bad++;
            $display("FAIL fault_flag: got f=%b i=%h, want 1 %h",
                     g.fault, g.instr, NOP);
          end
        end
        nf++;
      end
    end
    idle();
    n_cmp++;
    if (nf != 5) begin
      n_bad++;
      $display("FAIL fault_count: got %0d, want 5", nf);
    end
  endtask

  task automatic test_load();
    logic [IW-1:0] want [2] = '{32'hA5, 32'hDEAD};
    int   nf = 0;
    bit   a, f, u;
    rsp_t e, g;
    idle();
    bus.ld_we     = 1'b1;
    bus.ld_addr   = AW'(5);
    bus.ld_data   = 32'hDEAD;
    bus.req_valid = 1'b1;
    bus.req_pc    = 12'h014;
    clk_step(a, f, u, e, g);
    bus.ld_we = 1'b0;
    clk_step(a, f, u, e, g);
    bus.req_valid = 1'b0;
    for (int c = 0; c < 8 && nf < 2; c++) begin
      clk_step(a, f, u, e, g);
      if (f) begin
        n_cmp++;
        if (u || g !== e || g.instr !== want[nf]) begin
          n_bad++;
          $display("FAIL load_resp%0d: got %h/%h, want 014/%h extra=%b",
                   nf, g.pc, g.instr, want[nf], u);
        end
        nf++;
      end
    end
    n_cmp++;
    if (nf != 2) begin
      n_bad++;
      $display("FAIL load_count: got %0d, want 2", nf);
    end
  endtask

  task automatic test_reset_mid();
    logic [IW-1:0] want [2] = '{32'hA2, 32'hA7};
    logic [PW-1:0] pcs [2] = '{12'h008, 12'h01C};
    int   i = 0, nf = 0;
    bit   a, f, u;
    rsp_t e, g;
    idle();
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_pc     = 12'h000;
    clk_step(a, f, u, e, g);
    bus.req_pc     = 12'h004;
    clk_step(a, f, u, e, g);
    bus.req_valid  = 1'b0;
    #1;
    n_cmp++;
    if (bus.resp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_valid: got %b, want 1", bus.resp_valid);
    end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.resp_instr !== NOP ||
        bus.resp_pc !== '0 || bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b i=%h pc=%h rr=%b, want 0 %h 000 1",
               bus.resp_valid, bus.resp_instr, bus.resp_pc,
               bus.req_ready, NOP);
    end
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 12 && nf < 2; c++) begin
      bus.req_valid = (i < 2);
      if (i < 2) bus.req_pc = pcs[i];
      clk_step(a, f, u, e, g);
      if (a) i++;
      if (f) begin
        n_cmp++;
        if (u || g !== e || g.instr !== want[nf]) begin
          n_bad++;
          $display("FAIL post_reset_data%0d: got %h/%h, want %h/%h extra=%b",
                   nf, g.pc, g.instr, pcs[nf], want[nf], u);
        end
        nf++;
      end
    end
    idle();
    n_cmp++;
    if (nf != 2) begin
      n_bad++;
      $display("FAIL post_reset_count: got %0d, want 2", nf);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_fault();
    test_load();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
